modexp_engine: RTL
==================

// Module: modexp_engine
// PURPOSE
//   Parametrised modular exponentiation engine computing R = (A^B) mod C for
//   WIDTH-bit operands. Successor to the fixed 8-bit RSA datapath.
//   Uses right-to-left square-and-multiply over an internal bit-serial
//   interleaved modular multiplier, so no 2*WIDTH product register is needed.
//   Adds a start/done handshake, operand checks and early exit. Sits behind
//   the RSA key/message register file.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (legal range 4..64)
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous, active-low reset
//   start    in   1      request; accepted only when busy==0 (one-cycle pulse or level)
//   A        in   WIDTH  base; sampled on accept
//   B        in   WIDTH  exponent; sampled on accept
//   C        in   WIDTH  modulus; sampled on accept
//   busy     out  1      high from the cycle after accept until done
//   done     out  1      one-cycle pulse; result and err valid in that cycle and held after
//   err      out  1      set with done when C==0; cleared on the next accept
//   result   out  WIDTH  (A^B) mod C; held until the next done
// BEHAVIOUR
// Reset
//   - rst_n low: busy=0, done=0, err=0, result=0, FSM=IDLE; all work is dropped.
//   - Reset mid-operation aborts; no done is produced.
// Accept
//   - start && !busy in IDLE latches Cr=C, Er=B, base source A, clears err;
//     busy=1 next cycle.
//   - start while busy is ignored, with no effect on the running job.
// FSM
//   - IDLE
//   - CHECK (1 cycle): C==0 -> DONE, err=1, result=0; C==1 -> DONE, result=0;
//     else Y=1 and go to REDUCE.
//   - REDUCE (WIDTH cycles): X = A mod Cr by restoring shift-subtract, MSB first.
//   - LOOP (1 cycle): Er==0 -> DONE, result=Y.
//       Er[0]==1 -> MULY;
//       else -> SQRX.
//   - MULY (WIDTH cycles): Y = Y*X mod Cr. Then Er>>1 applied;
//     if new Er==0 -> DONE, else -> SQRX.
//   - SQRX (WIDTH cycles): X = X*X mod Cr. If entered from LOOP, Er>>1 is
//     applied on entry. Then -> LOOP.
//   - DONE (1 cycle): done=1, busy=0 in the same cycle; -> IDLE.
//     A new start in the DONE cycle is not accepted.
// Modular multiply (P = a*b mod Cr, a,b < Cr)
//   - P=0; for i=WIDTH-1..0:
//       P = 2P;   if P>=Cr then P-=Cr;
//       if b[i]:  P = P+a; if P>=Cr then P-=Cr.
//   - One bit per cycle. The internal P is WIDTH+1 bits (2P and P+a are < 2*Cr);
//     results are always < Cr.
// Arithmetic edge rules
//   - B==0 gives 1 mod C (1 for C>=2).
//   - A==0 with B>0 gives 0.
//   - A>=C is legal (reduced in REDUCE).
// Latency
//   - Accept -> done <= 3 + WIDTH + nb*(2*WIDTH+1) cycles, where nb = bit
//     length of B.
//   - The final squaring is skipped (early exit).
//   - Exact count is deterministic for given B and WIDTH.
// TESTING
//   1. WIDTH=16: A=4, B=13, C=497 -> done with result=445, err=0; latency within bound.
//   2. WIDTH=8: A=200, B=1, C=7 -> result=4.
//      A=7, B=0, C=13 -> result=1.
//   3. WIDTH=8 extremes: A=255, B=255, C=254 -> 1.
//      A=0, B=5, C=11 -> 0.
//      C=1 -> result=0, err=0.
//      C=0 -> err=1, result=0.
//   4. Start held high while busy, with A/B/C changed mid-job -> first
//      result unaffected; new job accepted only after the done cycle.
//   5. rst_n pulsed low mid-MULY -> busy/done/result/err = 0 immediately; next
//      job (A=3, B=200, C=101) gives 3^200 mod 101 = 1.
//   6. Random sweep, WIDTH=8 and 16, 10k vectors vs a behavioural model ->
//      zero mismatches.

Source files
------------

// File: rtl/modexp_if.sv
// Handshake/operand bundle for modexp_engine.
//   start        request (accepted only while the engine is idle)
//   A, B, C      base, exponent, modulus; sampled on accept
//   busy         engine working on a job
//   done         one-cycle completion pulse
//   err          modulus was zero
//   result       (A^B) mod C, held until the next done
// master: the requester side; slave: the engine side.
interface modexp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (output start, A, B, C, input busy, done, err, result);
    modport slave  (input start, A, B, C, output busy, done, err, result);
endinterface

// File: rtl/modexp_engine.sv
// Modular exponentiation engine: result = (A^B) mod C on WIDTH-bit operands.
// Right-to-left square-and-multiply built on a bit-serial interleaved modular
// multiplier (one multiplier bit per cycle), so no double-width product is kept.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    modexp_if.slave: start/A/B/C in, busy/done/err/result out
module modexp_engine #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    modexp_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REDUCE = 3'd2,
        S_LOOP   = 3'd3,
        S_MULY   = 3'd4,
        S_SQRX   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] c_r, e_r, x_r, y_r, p_r, result_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r, done_r, err_r;

    logic             accept_s, last_s, mul_b_s;
    logic [WIDTH-1:0] red_s, mul_s, e_shift_s;

    // Conditional subtract: v < 2*m is guaranteed by callers, so one subtract
    // fully reduces and the result always fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH:0] v,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] mm;
        mm = {1'b0, m};
        if (v >= mm) begin
            return WIDTH'(v - mm);
        end else begin
            return WIDTH'(v);
        end
    endfunction

    // One interleaved multiply step: P = 2P mod m, then (P + a) mod m if bit set.
    function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             b,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] t;
        t = mod_sub({p, 1'b0}, m);
        if (b) begin
            t = mod_sub({1'b0, t} + {1'b0, a}, m);
        end else begin
            t = t;
        end
        return t;
    endfunction

    assign accept_s  = bus.start && !busy_r && (state_r == S_IDLE);
    assign last_s    = (cnt_r == CW'(0));
    // Multiplier bit source: Y during MULY, X during SQRX; a is always X.
    assign mul_b_s   = (state_r == S_MULY) ? y_r[cnt_r] : x_r[cnt_r];
    assign mul_s     = mul_step(p_r, x_r, mul_b_s, c_r);
    // Restoring division step: the base is shifted out of x_r MSB first.
    assign red_s     = mod_sub({p_r, x_r[WIDTH-1]}, c_r);
    assign e_shift_s = {1'b0, e_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   state_s = accept_s ? S_CHECK : S_IDLE;
            S_CHECK:  state_s = (c_r == WIDTH'(0) || c_r == WIDTH'(1)) ? S_DONE : S_REDUCE;
            S_REDUCE: state_s = last_s ? S_LOOP : S_REDUCE;
            S_LOOP: begin
                if (e_r == WIDTH'(0)) begin
                    state_s = S_DONE;
                end else if (e_r[0]) begin
                    state_s = S_MULY;
                end else begin
                    state_s = S_SQRX;
                end
            end
            S_MULY: begin
                if (last_s) begin
                    // Early exit: no squaring after the last exponent bit.
                    state_s = (e_shift_s == WIDTH'(0)) ? S_DONE : S_SQRX;
                end else begin
                    state_s = S_MULY;
                end
            end
            S_SQRX:   state_s = last_s ? S_LOOP : S_SQRX;
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r      <= '0;
            e_r      <= '0;
            x_r      <= '0;
            y_r      <= '0;
            p_r      <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE) && (state_s != S_DONE);
            done_r <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        c_r   <= bus.C;
                        e_r   <= bus.B;
                        x_r   <= bus.A;
                        err_r <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (c_r == WIDTH'(0)) begin
                        err_r    <= 1'b1;
                        result_r <= '0;
                    end else if (c_r == WIDTH'(1)) begin
                        result_r <= '0;
                    end else begin
                        y_r   <= WIDTH'(1);
                        p_r   <= '0;
                        cnt_r <= CW'(WIDTH - 1);
                    end
                end
                S_REDUCE: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        x_r <= red_s;
                        p_r <= '0;
                    end else begin
                        x_r <= {x_r[WIDTH-2:0], 1'b0};
                        p_r <= red_s;
                    end
                end
                S_LOOP: begin
                    p_r   <= '0;
                    cnt_r <= CW'(WIDTH - 1);
                    if (e_r == WIDTH'(0)) begin
                        result_r <= y_r;
                    end else if (!e_r[0]) begin
                        // Entering SQRX directly: consume the zero exponent bit now.
                        e_r <= e_shift_s;
                    end
                end
                S_MULY: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        y_r   <= mul_s;
                        e_r   <= e_shift_s;
                        p_r   <= '0;
                        cnt_r <= CW'(WIDTH - 1);
                        if (e_shift_s == WIDTH'(0)) begin
                            result_r <= mul_s;
                        end
                    end else begin
                        p_r <= mul_s;
                    end
                end
                S_SQRX: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        x_r <= mul_s;
                        p_r <= '0;
                    end else begin
                        p_r <= mul_s;
                    end
                end
                S_DONE: begin
                    p_r <= '0;
                end
                default: begin
                    p_r <= '0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;
endmodule
